// File: rtl/dosing_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// dosing_sequencer_pkg
//   Shared definitions for the paint-dispenser dosing sequencer:
//   - state codes (also driven out on the est debug port)
//   - channel bit positions in motores/flags (R=2, Y=1, B=0)
//   - motor one-hot enable constants and the state-to-motor decode
// -----------------------------------------------------------------------------
package dosing_sequencer_pkg;

  typedef logic [2:0] state_t;

  // State codes. These values are visible on est, so they are fixed.
  localparam state_t ST_IDLE  = 3'b000;
  localparam state_t ST_RUN_R = 3'b001;
  localparam state_t ST_RUN_Y = 3'b010;
  localparam state_t ST_RUN_B = 3'b011;
  localparam state_t ST_GAP   = 3'b100;
  localparam state_t ST_DONE  = 3'b101;

  // Channel bit positions inside motores and flags.
  localparam int CH_R = 2;
  localparam int CH_Y = 1;
  localparam int CH_B = 0;

  // Motor one-hot enables.
  localparam logic [2:0] MOT_OFF   = 3'b000;
  localparam logic [2:0] MOT_R     = 3'b100;
  localparam logic [2:0] MOT_Y     = 3'b010;
  localparam logic [2:0] MOT_B     = 3'b001;
  localparam logic [2:0] FLAGS_ALL = 3'b111;

  // Moore decode of the motor enables from the state code alone.
  function automatic logic [2:0] motor_decode(input state_t st);
    logic [2:0] mot;
    mot = MOT_OFF;
    case (st)
      ST_RUN_R: mot = MOT_R;
      ST_RUN_Y: mot = MOT_Y;
      ST_RUN_B: mot = MOT_B;
      default:  mot = MOT_OFF;
    endcase
    return mot;
  endfunction

endpackage

// File: rtl/dosing_sequencer_timer.sv
// -----------------------------------------------------------------------------
// dose_timer
//   Times one motor run of amount*TICK_DIV cycles using a prescaler
//   (0..TICK_DIV-1) and a unit down-counter.
//   Ports:
//     clk     in   1      system clock
//     reset   in   1      synchronous active-high reset, clears both counters
//     load    in   1      clear the prescaler and load the unit counter
//     amount  in   AMT_W  units to load (load with 0 simply clears the timer)
//     enable  in   1      count this cycle (ignored while load is high)
//     expire  out  1      high on the last cycle of the run: prescaler at
//                         TICK_DIV-1 with one unit left and enable high
// -----------------------------------------------------------------------------
module dose_timer #(
  parameter int AMT_W    = 8,
  parameter int TICK_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [AMT_W-1:0] amount,
  input  logic             enable,
  output logic             expire
);

  localparam int             PW     = $clog2(TICK_DIV) + 1;
  localparam logic [PW-1:0]  P_LAST = PW'(TICK_DIV - 1);
  localparam logic [AMT_W-1:0] U_ONE = AMT_W'(1);

  logic [PW-1:0]    r_presc;
  logic [AMT_W-1:0] r_units;
  logic             w_tick;

  assign w_tick = (r_presc == P_LAST);
  assign expire = enable && w_tick && (r_units == U_ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_units <= '0;
    end else if (load) begin
      r_presc <= '0;
      r_units <= amount;
    end else if (enable) begin
      if (w_tick) begin
        r_presc <= '0;
        // Saturate at zero so the unit counter never wraps.
        if (r_units != '0) r_units <= r_units - U_ONE;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dosing_sequencer.sv
// -----------------------------------------------------------------------------
// dosing_sequencer
//   Runs the R, Y and B dispenser motors one at a time, in that order, each for
//   amt*TICK_DIV cycles, with GAP_CYCLES of dead time between two motors that
//   both run. Zero-amount channels are skipped. Produces sticky per-channel
//   done flags and a one-cycle done pulse.
//   Control semantics: start is a level sampled only in IDLE (ignored while
//   busy, never queued); abort wins over start and, while busy, returns the
//   sequencer to IDLE on the next edge with motors off and flags preserved.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     start, abort          control inputs
//     amt_r, amt_y, amt_b   dose amounts, latched on an accepted start
//     motores  out 3        one-hot motor enable [2]=R [1]=Y [0]=B
//     flags    out 3        sticky per-channel done flags
//     busy     out 1        high in every state except IDLE
//     done     out 1        one-cycle pulse on normal completion
//     est      out 3        current state code (debug/LEDs)
// -----------------------------------------------------------------------------
module dosing_sequencer
  import dosing_sequencer_pkg::*;
#(
  parameter int AMT_W      = 8,
  parameter int TICK_DIV   = 50000,
  parameter int GAP_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [AMT_W-1:0] amt_r,
  input  logic [AMT_W-1:0] amt_y,
  input  logic [AMT_W-1:0] amt_b,
  output logic [2:0]       motores,
  output logic [2:0]       flags,
  output logic             busy,
  output logic             done,
  output logic [2:0]       est
);

  localparam int               GAP_W    = $clog2(GAP_CYCLES) + 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t           r_state;
  state_t           w_next_state;
  state_t           r_next_run;   // RUN state to enter when the gap ends
  state_t           w_next_run;
  logic [AMT_W-1:0] r_amt_r;
  logic [AMT_W-1:0] r_amt_y;
  logic [AMT_W-1:0] r_amt_b;
  logic [2:0]       r_flags;
  logic [2:0]       w_flags_set;
  logic             w_flags_clr;
  logic             w_latch;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] w_gap_next;
  logic             w_load;
  logic [AMT_W-1:0] w_load_amt;
  logic             w_enable;
  logic             w_expire;

  assign w_enable = (r_state == ST_RUN_R) || (r_state == ST_RUN_Y) ||
                    (r_state == ST_RUN_B);

  dose_timer #(
    .AMT_W    (AMT_W),
    .TICK_DIV (TICK_DIV)
  ) u_dose_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (w_load),
    .amount (w_load_amt),
    .enable (w_enable),
    .expire (w_expire)
  );

  // Next-state logic. Skipped channels have their flag set on the same edge
  // the sequence moves past them, which is why several flag bits can be set
  // at once below.
  always_comb begin
    w_next_state = r_state;
    w_next_run   = r_next_run;
    w_flags_set  = 3'b000;
    w_flags_clr  = 1'b0;
    w_latch      = 1'b0;
    w_gap_next   = r_gap;
    w_load       = 1'b0;
    w_load_amt   = '0;

    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_latch     = 1'b1;
          w_flags_clr = 1'b1;
          w_load      = 1'b1;
          if (amt_r != '0) begin
            w_next_state = ST_RUN_R;
            w_load_amt   = amt_r;
          end else if (amt_y != '0) begin
            w_next_state       = ST_RUN_Y;
            w_load_amt         = amt_y;
            w_flags_set[CH_R]  = 1'b1;
          end else if (amt_b != '0) begin
            w_next_state       = ST_RUN_B;
            w_load_amt         = amt_b;
            w_flags_set[CH_R]  = 1'b1;
            w_flags_set[CH_Y]  = 1'b1;
          end else begin
            w_next_state = ST_DONE;
            w_flags_set  = FLAGS_ALL;
          end
        end
      end

      ST_RUN_R: begin
        if (w_expire) begin
          w_flags_set[CH_R] = 1'b1;
          if (r_amt_y != '0) begin
            w_next_state = ST_GAP;
            w_next_run   = ST_RUN_Y;
          end else if (r_amt_b != '0) begin
            w_next_state      = ST_GAP;
            w_next_run        = ST_RUN_B;
            w_flags_set[CH_Y] = 1'b1;
          end else begin
            w_next_state = ST_DONE;
            w_flags_set  = FLAGS_ALL;
          end
        end
      end

      ST_RUN_Y: begin
        if (w_expire) begin
          w_flags_set[CH_Y] = 1'b1;
          if (r_amt_b != '0) begin
            w_next_state = ST_GAP;
            w_next_run   = ST_RUN_B;
          end else begin
            w_next_state = ST_DONE;
            w_flags_set  = FLAGS_ALL;
          end
        end
      end

      ST_RUN_B: begin
        if (w_expire) begin
          w_next_state      = ST_DONE;
          w_flags_set[CH_B] = 1'b1;
        end
      end

      ST_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_next_state = r_next_run;
          w_gap_next   = '0;
          w_load       = 1'b1;
          w_load_amt   = (r_next_run == ST_RUN_Y) ? r_amt_y :
                         (r_next_run == ST_RUN_B) ? r_amt_b : r_amt_r;
        end else begin
          w_gap_next = r_gap + 1'b1;
        end
      end

      ST_DONE: begin
        w_next_state = ST_IDLE;
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    // Abort overrides everything except reset. Loading the timer with zero
    // clears both of its counters; flags are left untouched.
    if (abort && (r_state != ST_IDLE)) begin
      w_next_state = ST_IDLE;
      w_flags_set  = 3'b000;
      w_flags_clr  = 1'b0;
      w_latch      = 1'b0;
      w_gap_next   = '0;
      w_load       = 1'b1;
      w_load_amt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_next_run <= ST_RUN_R;
      r_amt_r    <= '0;
      r_amt_y    <= '0;
      r_amt_b    <= '0;
      r_flags    <= 3'b000;
      r_gap      <= '0;
    end else begin
      r_state    <= w_next_state;
      r_next_run <= w_next_run;
      r_gap      <= w_gap_next;
      r_flags    <= (w_flags_clr ? 3'b000 : r_flags) | w_flags_set;
      if (w_latch) begin
        r_amt_r <= amt_r;
        r_amt_y <= amt_y;
        r_amt_b <= amt_b;
      end
    end
  end

  assign motores = motor_decode(r_state);
  assign flags   = r_flags;
  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign est     = r_state;

endmodule

// File: tb/tb_dosing_sequencer.sv
module tb_dosing_sequencer;

  localparam int AMT_W      = 8;
  localparam int TICK_DIV   = 4;
  localparam int GAP_CYCLES = 2;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [AMT_W-1:0] amt_r;
  logic [AMT_W-1:0] amt_y;
  logic [AMT_W-1:0] amt_b;
  logic [2:0]       motores;
  logic [2:0]       flags;
  logic             busy;
  logic             done;
  logic [2:0]       est;

  always #5 clk = ~clk;

  dosing_sequencer #(
    .AMT_W      (AMT_W),
    .TICK_DIV   (TICK_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .amt_r   (amt_r),
    .amt_y   (amt_y),
    .amt_b   (amt_b),
    .motores (motores),
    .flags   (flags),
    .busy    (busy),
    .done    (done),
    .est     (est)
  );

  // ---------------- behavioural model ----------------
  // One entry per cycle: what every output must show during that cycle.
  typedef struct packed {
    logic [2:0] mot;
    logic [2:0] flg;
    logic       busy;
    logic       done;
    logic [2:0] est;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];   // future cycles of the current sequence
  exp_t             cur = '0;   // expected outputs for the present cycle
  int               n_checks = 0;
  int               n_fail   = 0;
  bit               chk_en   = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Whole-sequence timeline from the rules: channels in R,Y,B order, each
  // nonzero channel runs amt*TICK_DIV cycles, a gap sits between two runs,
  // skipped channels are flagged when the sequence passes them, then DONE.
  function automatic void build_timeline(logic [AMT_W-1:0] ar, logic [AMT_W-1:0] ay,
                                         logic [AMT_W-1:0] ab);
    logic [AMT_W-1:0] a[3];
    logic [2:0] f    = 3'b000;
    logic [2:0] pend = 3'b000;
    logic [2:0] bitm;
    bit         first = 1'b1;
    a[0] = ar; a[1] = ay; a[2] = ab;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      bitm = 3'(4 >> k);
      if (a[k] == '0) begin
        pend |= bitm;
        continue;
      end
      f |= pend;
      pend = 3'b000;
      if (!first)
        for (int g = 0; g < GAP_CYCLES; g++)
          exp_q.push_back({3'b000, f, 1'b1, 1'b0, 3'b100});
      for (int c = 0; c < int'(a[k]) * TICK_DIV; c++)
        exp_q.push_back({bitm, f, 1'b1, 1'b0, 3'(k + 1)});
      f |= bitm;
      first = 1'b0;
    end
    exp_q.push_back({3'b000, 3'b111, 1'b1, 1'b1, 3'b101});
  endfunction

  // Outputs after a clock edge, given the inputs sampled at that edge.
  function automatic void model_edge(bit rst, bit st, bit ab,
                                     logic [AMT_W-1:0] ar, logic [AMT_W-1:0] ay,
                                     logic [AMT_W-1:0] abl);
    if (rst) begin
      exp_q.delete();
      cur = '0;
    end else if (cur.busy && ab) begin
      exp_q.delete();
      cur = {3'b000, cur.flg, 1'b0, 1'b0, 3'b000};
    end else if (!cur.busy && st && !ab) begin
      build_timeline(ar, ay, abl);
      cur = exp_q.pop_front();
    end else if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
    end else begin
      cur = {3'b000, cur.flg, 1'b0, 1'b0, 3'b000};
    end
  endfunction

  // ---------------- driver ----------------
  task automatic step(bit rst, bit st, bit ab);
    reset = rst;
    start = st;
    abort = ab;
    @(posedge clk);
    model_edge(rst, st, ab, amt_r, amt_y, amt_b);
    if (rst) chk_en = 1'b1;
    #1;
  endtask

  task automatic set_amts(int r, int y, int b);
    amt_r = AMT_W'(r);
    amt_y = AMT_W'(y);
    amt_b = AMT_W'(b);
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("motores", 32'(motores), 32'(cur.mot));
      chk("flags",   32'(flags),   32'(cur.flg));
      chk("busy",    32'(busy),    32'(cur.busy));
      chk("done",    32'(done),    32'(cur.done));
      chk("est",     32'(est),     32'(cur.est));
    end
  end

  // Nominal 3/2/1 run, optionally with start pulses during RUN_Y.
  task automatic nominal_run(bit with_ignored_start);
    set_amts(3, 2, 1);
    step(1'b0, 1'b1, 1'b0);               // start in cycle 0
    for (int c = 1; c <= 31; c++) begin
      @(negedge clk);
      if (c == 1 || c == 12)  chk("nom_mot_r",  32'(motores), 32'b100);
      if (c == 13 || c == 14) chk("nom_gap1",   32'(motores), 32'b000);
      if (c == 15 || c == 22) chk("nom_mot_y",  32'(motores), 32'b010);
      if (c == 23 || c == 24) chk("nom_gap2",   32'(motores), 32'b000);
      if (c == 25 || c == 28) chk("nom_mot_b",  32'(motores), 32'b001);
      if (c == 29) begin
        chk("nom_done",  32'(done),  32'd1);
        chk("nom_flags", 32'(flags), 32'b111);
      end
      if (c == 30 || c == 31) begin
        chk("nom_busy_end", 32'(busy), 32'd0);
        chk("nom_est_end",  32'(est),  32'd0);
      end
      if (with_ignored_start && (c == 16 || c == 20)) set_amts($urandom_range(0, 9), 7, 7);
      step(1'b0, with_ignored_start && (c >= 16 && c <= 18 || c == 20), 1'b0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    set_amts(0, 0, 0);

    step(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_est",   32'(est),   32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    step(1'b0, 1'b0, 1'b0);

    // Nominal run and the same run with ignored starts while busy.
    nominal_run(1'b0);
    nominal_run(1'b1);

    // Skip channel: 2/0/1 -> R 1-8, gap 9-10, B 11-14, DONE 15.
    set_amts(2, 0, 1);
    step(1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      chk("skip_no_y", 32'(motores[1]), 32'd0);
      if (c == 8)  chk("skip_r_end",  32'(motores), 32'b100);
      if (c == 9)  chk("skip_flag_y", 32'(flags),   32'b110);
      if (c == 11) chk("skip_b_on",   32'(motores), 32'b001);
      if (c == 15) chk("skip_done",   32'(done),    32'd1);
      step(1'b0, 1'b0, 1'b0);
    end

    // All zero: DONE in cycle 1, IDLE in cycle 2.
    set_amts(0, 0, 0);
    step(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("zero_est1",  32'(est),   32'b101);
    chk("zero_done",  32'(done),  32'd1);
    chk("zero_flags", 32'(flags), 32'b111);
    step(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("zero_est2", 32'(est),  32'd0);
    chk("zero_busy", 32'(busy), 32'd0);
    idle_cycles(2);

    // Abort in cycle 6, restart in cycle 9 with fresh amounts 1/2/3.
    set_amts(5, 5, 5);
    step(1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c >= 7 && c <= 9) begin
        chk("abort_mot",   32'(motores), 32'd0);
        chk("abort_flags", 32'(flags),   32'd0);
        chk("abort_done",  32'(done),    32'd0);
      end
      if (c == 10 || c == 13) chk("restart_r", 32'(motores), 32'b100);
      if (c == 14)            chk("restart_gap", 32'(motores), 32'b000);
      if (c == 9) set_amts(1, 2, 3);
      step(1'b0, c == 9, c == 6);
    end
    idle_cycles(30);

    // Reset in the middle of RUN_Y: 1/2/1 -> R 1-4, gap 5-6, Y 7-14.
    set_amts(1, 2, 1);
    step(1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 8) begin
        chk("mid_y_mot",   32'(motores), 32'b010);
        chk("mid_y_flags", 32'(flags),   32'b100);
      end
      if (c == 10) begin
        chk("rst_mid_mot",   32'(motores), 32'd0);
        chk("rst_mid_flags", 32'(flags),   32'd0);
        chk("rst_mid_busy",  32'(busy),    32'd0);
        chk("rst_mid_est",   32'(est),     32'd0);
      end
      step(c == 9, 1'b0, 1'b0);
    end

    // Randomized traffic: random amounts that also change while busy,
    // random starts, occasional aborts and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0)
        set_amts($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
      step($urandom_range(0, 499) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 79) == 0);
    end
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
